// File: rtl/processor_pkg.sv
// Shared processor definitions: instruction opcodes and the program loader state encoding.
// Imported by the program loader and by the control unit, so both agree on opcode values.
package processor_pkg;

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;

  typedef enum logic [2:0] {
    StIdle,
    StGetHi,
    StGetLo,
    StWrite,
    StDone,
    StErr
  } loader_state_e;

  // Opcode lives in the top nibble of every instruction word.
  function automatic logic is_opcode(logic [15:0] word, logic [3:0] op);
    return word[15:12] == op;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Program loader bus bundle: the incoming byte stream (valid/ready) and the
// instruction-memory write port.
//   byte_in/byte_valid : stream source -> loader
//   byte_ready         : loader -> stream source
//   I_addr/I_data/I_wr : loader -> instruction memory
// master = loader side, slave = stream source / memory side.
interface program_loader_if #(
  parameter int unsigned ADDR_W = 7
) ();

  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic [ADDR_W-1:0] I_addr;
  logic [15:0]       I_data;
  logic              I_wr;

  modport master (
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output I_addr,
    output I_data,
    output I_wr
  );

  modport slave (
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  I_addr,
    input  I_data,
    input  I_wr
  );

endinterface

// File: rtl/loader_word_assembler.sv
// Packs two stream bytes (high byte first) into a 16-bit instruction word.
//   clk, reset    : clock, async active-low reset
//   hi_load       : capture byte_in as the high byte
//   lo_load       : combine latched high byte with byte_in into word
//   byte_in       : stream byte
//   word          : last assembled word (registered)
//   word_complete : high for the one cycle after lo_load, while word is fresh
module loader_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic        hi_load,
  input  logic        lo_load,
  input  logic [7:0]  byte_in,
  output logic [15:0] word,
  output logic        word_complete
);

  logic [7:0]  hi_q;
  logic [15:0] word_q;
  logic        complete_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q       <= 8'h00;
      word_q     <= 16'h0000;
      complete_q <= 1'b0;
    end else begin
      if (hi_load) begin
        hi_q <= byte_in;
      end
      if (lo_load) begin
        word_q <= {hi_q, byte_in};
      end
      complete_q <= lo_load;
    end
  end

  assign word          = word_q;
  assign word_complete = complete_q;

endmodule

// File: rtl/program_loader.sv
// Program loader: fills instruction memory from a byte stream and holds the
// processor in reset until a HALT word has been written.
//   clk, reset  : clock, async active-low reset
//   start       : begin a load (honoured in idle, done or error only)
//   bus         : byte stream handshake and instruction-memory write port
//   proc_reset  : active-low processor reset, released only once loading is done
//   done        : load finished with HALT written
//   error       : memory filled without a HALT word
//   word_count  : words written in the current load
module program_loader
  import processor_pkg::*;
#(
  parameter int unsigned ADDR_W  = 7,
  parameter logic [3:0]  HALT_OP = OP_HALT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  program_loader_if.master  bus,
  output logic              proc_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W:0] Capacity = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CountOne = {{ADDR_W{1'b0}}, 1'b1};

  loader_state_e     state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hi_load, lo_load;
  logic [15:0]       word;
  logic              word_complete;

  loader_word_assembler u_assembler (
    .clk           (clk),
    .reset         (reset),
    .hi_load       (hi_load),
    .lo_load       (lo_load),
    .byte_in       (bus.byte_in),
    .word          (word),
    .word_complete (word_complete)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      count_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    hi_load = 1'b0;
    lo_load = 1'b0;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StGetHi;
          count_d = '0;
        end
      end
      StGetHi: begin
        if (bus.byte_valid) begin
          hi_load = 1'b1;
          state_d = StGetLo;
        end
      end
      StGetLo: begin
        if (bus.byte_valid) begin
          lo_load = 1'b1;
          addr_d  = count_q[ADDR_W-1:0];
          state_d = StWrite;
        end
      end
      StWrite: begin
        count_d = count_q + CountOne;
        // HALT wins even on the last address, so a full memory ending in HALT is a success.
        if (is_opcode(word, HALT_OP)) begin
          state_d = StDone;
        end else if (count_d == Capacity) begin
          state_d = StErr;
        end else begin
          state_d = StGetHi;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // All outputs come from registers or state decode; byte_valid never reaches them directly.
  assign bus.byte_ready = (state_q == StGetHi) || (state_q == StGetLo);
  assign bus.I_addr     = addr_q;
  assign bus.I_data     = word;
  assign bus.I_wr       = word_complete;
  assign proc_reset     = (state_q == StDone);
  assign done           = (state_q == StDone);
  assign error          = (state_q == StErr);
  assign word_count     = count_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
  import processor_pkg::*;

  localparam int unsigned AW  = 7;
  localparam int          CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          proc_reset, done, error;
  logic [AW:0]   word_count;

  program_loader_if #(.ADDR_W(AW)) bus ();

  program_loader #(.ADDR_W(AW), .HALT_OP(4'd5)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .proc_reset (proc_reset),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int pat_idx = 0;

  logic [15:0]   stim_q[$];
  logic [AW-1:0] wr_addr_q[$];
  logic [15:0]   wr_data_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: records every memory write; a write must never overlap byte acceptance.
  always @(negedge clk) begin
    if (bus.I_wr === 1'b1) begin
      wr_addr_q.push_back(bus.I_addr);
      wr_data_q.push_back(bus.I_data);
      chk("ready_during_write", {31'd0, bus.byte_ready}, 32'd0);
    end
  end

  function automatic logic [15:0] rand_nonhalt();
    logic [15:0] w;
    w = 16'($urandom_range(0, 65535));
    if (w[15:12] == 4'd5) w[15:12] = 4'($urandom_range(6, 15));
    return w;
  endfunction

  // stall < 0 uses the fixed valid pattern 1,0,0,1; otherwise percentage of idle cycles.
  task automatic send_byte(input logic [7:0] b, input int stall);
    int  guard;
    bit  sent;
    guard = 0;
    sent  = 0;
    while (!sent) begin
      @(negedge clk);
      bus.byte_in = b;
      if (stall < 0) begin
        bus.byte_valid = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
        pat_idx++;
      end else begin
        bus.byte_valid = ($urandom_range(0, 99) >= stall);
      end
      if (bus.byte_valid && bus.byte_ready) begin
        @(posedge clk);
        sent = 1;
      end
      guard++;
      if (!sent && guard > 200) begin
        fails++;
        $display("FAIL send_byte_timeout observed=no_transfer expected=transfer");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "byte stream stuck");
      end
    end
  endtask

  task automatic begin_load(input string tag);
    wr_addr_q.delete();
    wr_data_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".start_ready"}, {31'd0, bus.byte_ready}, 32'd1);
    chk({tag, ".start_proc_reset"}, {31'd0, proc_reset}, 32'd0);
    chk({tag, ".start_count"}, {24'd0, word_count}, 32'd0);
    chk({tag, ".start_done"}, {31'd0, done}, 32'd0);
  endtask

  // Reference: words are stored at consecutive addresses until the first HALT or until the
  // memory is full; the number consumed is what the source must supply.
  task automatic model(output int n, output bit exp_done);
    n = 0;
    exp_done = 0;
    for (int i = 0; i < stim_q.size() && i < CAP; i++) begin
      n = i + 1;
      if (stim_q[i][15:12] == 4'd5) begin
        exp_done = 1;
        break;
      end
    end
  endtask

  task automatic finish_check(input string tag, input int n, input bit exp_done);
    int guard;
    @(negedge clk);
    bus.byte_valid = 1'b0;
    guard = 0;
    while (!(done || error) && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk({tag, ".done"}, {31'd0, done}, {31'd0, exp_done});
    chk({tag, ".error"}, {31'd0, error}, {31'd0, !exp_done});
    chk({tag, ".proc_reset"}, {31'd0, proc_reset}, {31'd0, exp_done});
    chk({tag, ".word_count"}, {24'd0, word_count}, n);
    chk({tag, ".writes"}, wr_addr_q.size(), n);
    for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
      chk($sformatf("%s.addr%0d", tag, i), {25'd0, wr_addr_q[i]}, i);
      chk($sformatf("%s.data%0d", tag, i), {16'd0, wr_data_q[i]}, {16'd0, stim_q[i]});
    end
  endtask

  task automatic run_load(input string tag, input int stall);
    int n;
    bit exp_done;
    model(n, exp_done);
    begin_load(tag);
    for (int i = 0; i < n; i++) begin
      send_byte(stim_q[i][15:8], stall);
      send_byte(stim_q[i][7:0], stall);
    end
    finish_check(tag, n, exp_done);
  endtask

  initial begin
    int n;
    bit exp_done;
    int len;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst.byte_ready", {31'd0, bus.byte_ready}, 32'd0);
    chk("rst.I_addr", {25'd0, bus.I_addr}, 32'd0);
    chk("rst.I_data", {16'd0, bus.I_data}, 32'd0);
    chk("rst.I_wr", {31'd0, bus.I_wr}, 32'd0);
    chk("rst.proc_reset", {31'd0, proc_reset}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.error", {31'd0, error}, 32'd0);
    chk("rst.word_count", {24'd0, word_count}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle.byte_ready", {31'd0, bus.byte_ready}, 32'd0);

    // Basic load, continuous valid
    stim_q = '{16'h1F29, 16'h20A7, 16'h5000};
    run_load("basic", 0);

    // Stalled source, valid pattern 1,0,0,1
    pat_idx = 0;
    run_load("stall", -1);

    // Overflow: full memory, no HALT
    stim_q.delete();
    for (int i = 0; i < CAP; i++) stim_q.push_back(16'h3123);
    run_load("overflow", 0);

    // HALT in the last slot
    stim_q.delete();
    for (int i = 0; i < CAP - 1; i++) stim_q.push_back(16'h0000);
    stim_q.push_back(16'h5000);
    run_load("halt_last", 0);

    // Reset mid-load, after two words and a lone high byte
    begin_load("midrst");
    send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'h23, 0); send_byte(8'h45, 0);
    send_byte(8'h31, 0);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("midrst.I_wr", {31'd0, bus.I_wr}, 32'd0);
    chk("midrst.proc_reset", {31'd0, proc_reset}, 32'd0);
    chk("midrst.byte_ready", {31'd0, bus.byte_ready}, 32'd0);
    chk("midrst.word_count", {24'd0, word_count}, 32'd0);
    chk("midrst.I_addr", {25'd0, bus.I_addr}, 32'd0);
    chk("midrst.I_data", {16'd0, bus.I_data}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    stim_q = '{16'h5000};
    run_load("after_rst", 0);

    // start while in GET_LO is ignored
    stim_q = '{16'h2345, 16'h5000};
    begin_load("ign_start");
    send_byte(8'h23, 0);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_start.ready", {31'd0, bus.byte_ready}, 32'd1);
    chk("ign_start.count", {24'd0, word_count}, 32'd0);
    send_byte(8'h45, 0);
    send_byte(8'h50, 0);
    send_byte(8'h00, 0);
    finish_check("ign_start", 2, 1'b1);

    // Reload straight out of DONE
    stim_q = '{16'h4012, 16'h5000};
    run_load("reload", 0);

    // Random loads: HALT at a random position with trailing words after it
    for (int k = 0; k < 6; k++) begin
      stim_q.delete();
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) stim_q.push_back(rand_nonhalt());
      stim_q[$urandom_range(0, len - 1)] = {4'd5, 12'($urandom_range(0, 4095))};
      run_load($sformatf("rand%0d", k), $urandom_range(0, 70));
    end

    // Random words without HALT beyond capacity
    stim_q.delete();
    for (int i = 0; i < CAP + 2; i++) stim_q.push_back(rand_nonhalt());
    model(n, exp_done);
    run_load("rand_full", 20);
    chk("rand_full.model_n", n, CAP);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
